// File: rtl/msrh_sched_age_picker_if.sv
// Dispatch/entry-array/issue bundle of the scheduler age picker.
// The picker takes the slave modport; the driving environment takes master.
interface msrh_sched_age_picker_if #(
    parameter int unsigned ENTRY_SIZE = 8,
    parameter int unsigned PUT_NUM    = 2
);
    localparam int unsigned IDX_W = $clog2(ENTRY_SIZE);

    logic [PUT_NUM-1:0]            i_put_vld;
    logic [PUT_NUM*ENTRY_SIZE-1:0] o_put_entry_oh;
    logic                          o_full;
    logic [ENTRY_SIZE-1:0]         i_entry_ready;
    logic [ENTRY_SIZE-1:0]         i_entry_finish;
    logic                          i_pipe_stall;
    logic [ENTRY_SIZE-1:0]         o_pick_oh;
    logic                          o_iss_valid;
    logic [IDX_W-1:0]              o_iss_idx;
    logic [ENTRY_SIZE-1:0]         o_valid_vec;

    modport master (
        output i_put_vld,
        output i_entry_ready,
        output i_entry_finish,
        output i_pipe_stall,
        input  o_put_entry_oh,
        input  o_full,
        input  o_pick_oh,
        input  o_iss_valid,
        input  o_iss_idx,
        input  o_valid_vec
    );

    modport slave (
        input  i_put_vld,
        input  i_entry_ready,
        input  i_entry_finish,
        input  i_pipe_stall,
        output o_put_entry_oh,
        output o_full,
        output o_pick_oh,
        output o_iss_valid,
        output o_iss_idx,
        output o_valid_vec
    );
endinterface

// File: rtl/msrh_sched_age_picker.sv
// Scheduler entry allocator plus age-matrix oldest-ready picker with issue register.
// Optional MSRH_SCHED_PICK_PERF_EN adds a saturating ready-but-stalled cycle counter.
module msrh_sched_age_picker #(
    parameter int unsigned ENTRY_SIZE = 8,
    parameter int unsigned PUT_NUM    = 2
) (
    input  logic                          i_clk,
    input  logic                          i_reset_n,
    msrh_sched_age_picker_if.slave        bus
`ifdef MSRH_SCHED_PICK_PERF_EN
    ,
    output logic [31:0]                   o_perf_ready_stall_cnt
`endif
);

    localparam int unsigned IDX_W = $clog2(ENTRY_SIZE);

    typedef logic [ENTRY_SIZE-1:0] vec_t;

    // age_q[j][i] set means entry j is older than entry i.
    vec_t                   valid_q, valid_d;
    vec_t [ENTRY_SIZE-1:0]  age_q, age_d;
    logic                   iss_valid_q, iss_valid_d;
    logic [IDX_W-1:0]       iss_idx_q, iss_idx_d;

    vec_t [PUT_NUM-1:0]     put_oh;
    vec_t [PUT_NUM-1:0]     put_earlier;
    vec_t [PUT_NUM-1:0]     put_later;
    logic [PUT_NUM-1:0]     put_go;
    vec_t                   put_mask;
    vec_t                   fin_eff;
    logic                   full;
    vec_t                   cand;
    vec_t                   winner;

    function automatic vec_t lowest_one(input vec_t v);
        vec_t r;
        logic found;
        r     = '0;
        found = 1'b0;
        for (int unsigned i = 0; i < ENTRY_SIZE; i++) begin
            if (v[i] && !found) begin
                r[i]  = 1'b1;
                found = 1'b1;
            end
        end
        return r;
    endfunction

    function automatic logic [IDX_W:0] count_ones(input vec_t v);
        logic [IDX_W:0] c;
        c = '0;
        for (int unsigned i = 0; i < ENTRY_SIZE; i++) begin
            c = c + {{IDX_W{1'b0}}, v[i]};
        end
        return c;
    endfunction

    function automatic logic [IDX_W-1:0] encode_oh(input vec_t oh);
        logic [IDX_W-1:0] idx;
        idx = '0;
        for (int unsigned i = 0; i < ENTRY_SIZE; i++) begin
            if (oh[i]) begin
                idx = idx | IDX_W'(i);
            end
        end
        return idx;
    endfunction

    // Valid pairs are ordered exactly one way; free rows/columns and the diagonal are zero.
    function automatic logic age_consistent(input vec_t v, input vec_t [ENTRY_SIZE-1:0] a);
        logic ok;
        ok = 1'b1;
        for (int unsigned i = 0; i < ENTRY_SIZE; i++) begin
            for (int unsigned j = 0; j < ENTRY_SIZE; j++) begin
                if (i == j) begin
                    if (a[i][j]) ok = 1'b0;
                end else if (v[i] && v[j]) begin
                    if (a[i][j] == a[j][i]) ok = 1'b0;
                end else if (a[i][j]) begin
                    ok = 1'b0;
                end
            end
        end
        return ok;
    endfunction

    // Allocation: each slot takes the lowest free entry left over by the slots before it.
    always_comb begin
        vec_t avail;
        avail = ~valid_q;
        for (int unsigned s = 0; s < PUT_NUM; s++) begin
            put_oh[s] = lowest_one(avail);
            avail     = avail & ~put_oh[s];
        end
    end

    assign full = count_ones(~valid_q) < (IDX_W + 1)'(PUT_NUM);

    always_comb begin
        vec_t acc;
        put_go   = bus.i_put_vld & {PUT_NUM{~full}};
        put_mask = '0;
        acc      = '0;
        for (int unsigned s = 0; s < PUT_NUM; s++) begin
            put_earlier[s] = acc;
            if (put_go[s]) begin
                acc      = acc | put_oh[s];
                put_mask = put_mask | put_oh[s];
            end
        end
        acc = '0;
        for (int s = int'(PUT_NUM) - 1; s >= 0; s--) begin
            put_later[s] = acc;
            if (put_go[s]) begin
                acc = acc | put_oh[s];
            end
        end
    end

    assign fin_eff = bus.i_entry_finish & valid_q;

    // Next-state valid vector and age matrix; finish clears are applied after puts.
    always_comb begin
        valid_d = (valid_q | put_mask) & ~fin_eff;
        age_d   = age_q;
        for (int unsigned s = 0; s < PUT_NUM; s++) begin
            for (int unsigned k = 0; k < ENTRY_SIZE; k++) begin
                if (put_go[s] && put_oh[s][k]) begin
                    for (int unsigned j = 0; j < ENTRY_SIZE; j++) begin
                        age_d[k][j] = put_later[s][j];
                        age_d[j][k] = valid_q[j] | put_earlier[s][j];
                    end
                end
            end
        end
        for (int unsigned k = 0; k < ENTRY_SIZE; k++) begin
            if (fin_eff[k]) begin
                age_d[k] = '0;
                for (int unsigned j = 0; j < ENTRY_SIZE; j++) begin
                    age_d[j][k] = 1'b0;
                end
            end
        end
    end

    // Oldest-ready pick: a candidate wins when no other candidate is older.
    always_comb begin
        vec_t older_col;
        cand   = bus.i_entry_ready & valid_q;
        winner = '0;
        for (int unsigned i = 0; i < ENTRY_SIZE; i++) begin
            for (int unsigned j = 0; j < ENTRY_SIZE; j++) begin
                older_col[j] = age_q[j][i];
            end
            winner[i] = cand[i] & ~|(cand & older_col);
        end
    end

    always_comb begin
        iss_valid_d = iss_valid_q;
        iss_idx_d   = iss_idx_q;
        if (!bus.i_pipe_stall) begin
            iss_valid_d = |cand;
            iss_idx_d   = encode_oh(winner);
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            valid_q     <= '0;
            age_q       <= '0;
            iss_valid_q <= 1'b0;
            iss_idx_q   <= '0;
        end else begin
            valid_q     <= valid_d;
            age_q       <= age_d;
            iss_valid_q <= iss_valid_d;
            iss_idx_q   <= iss_idx_d;
        end
    end

    always_comb begin
        for (int unsigned s = 0; s < PUT_NUM; s++) begin
            bus.o_put_entry_oh[s*ENTRY_SIZE +: ENTRY_SIZE] = put_oh[s];
        end
    end

    assign bus.o_full      = full;
    assign bus.o_pick_oh   = bus.i_pipe_stall ? '0 : winner;
    assign bus.o_iss_valid = iss_valid_q;
    assign bus.o_iss_idx   = iss_idx_q;
    assign bus.o_valid_vec = valid_q;

`ifdef MSRH_SCHED_PICK_PERF_EN
    logic [31:0] perf_cnt_q, perf_cnt_d;

    always_comb begin
        perf_cnt_d = perf_cnt_q;
        if ((|cand) && bus.i_pipe_stall && (perf_cnt_q != 32'hFFFF_FFFF)) begin
            perf_cnt_d = perf_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            perf_cnt_q <= '0;
        end else begin
            perf_cnt_q <= perf_cnt_d;
        end
    end

    assign o_perf_ready_stall_cnt = perf_cnt_q;
`endif

    a_pick_onehot: assert property (@(posedge i_clk) disable iff (!i_reset_n)
        $onehot0(winner));
    a_pick_exists: assert property (@(posedge i_clk) disable iff (!i_reset_n)
        (|cand) |-> (|winner));
    a_age_order: assert property (@(posedge i_clk) disable iff (!i_reset_n)
        age_consistent(valid_q, age_q));

endmodule

// File: tb/tb_msrh_sched_age_picker.sv
// Scoreboard bench for msrh_sched_age_picker: a queue-of-ages reference model
// predicts every cycle's outputs; a negedge monitor pops and compares.
module tb_msrh_sched_age_picker;

    localparam int E  = 8;
    localparam int P  = 2;
    localparam int IW = $clog2(E);

    typedef struct {
        logic [E-1:0]   pick;
        logic           full;
        logic [P*E-1:0] put_oh;
        logic [E-1:0]   vv;
        logic           iv;
        logic [IW-1:0]  idx;
        logic [31:0]    perf;
    } exp_t;

    logic clk;
    logic rst_n;
    logic [31:0] perf_cnt;

    msrh_sched_age_picker_if #(.ENTRY_SIZE(E), .PUT_NUM(P)) bus ();

    msrh_sched_age_picker #(.ENTRY_SIZE(E), .PUT_NUM(P)) dut (
        .i_clk     (clk),
        .i_reset_n (rst_n),
        .bus       (bus.slave)
`ifdef MSRH_SCHED_PICK_PERF_EN
        ,
        .o_perf_ready_stall_cnt (perf_cnt)
`endif
    );

`ifndef MSRH_SCHED_PICK_PERF_EN
    assign perf_cnt = '0;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;

    // Reference model: entries listed oldest first.
    int          mq[$];
    logic        m_iss_v;
    logic [IW-1:0] m_iss_idx;
    logic [31:0] m_perf;

    task automatic model_reset();
        mq.delete();
        m_iss_v   = 1'b0;
        m_iss_idx = '0;
        m_perf    = '0;
    endtask

    task automatic apply_cycle(input logic [P-1:0] pv, input logic [E-1:0] rdy,
                               input logic [E-1:0] fin, input logic st);
        exp_t e;
        int   free_list[$];
        int   win;
        logic [E-1:0] vmask;
        logic [E-1:0] one;
        one   = 1;
        vmask = '0;
        foreach (mq[q]) vmask[mq[q]] = 1'b1;
        for (int k = 0; k < E; k++) if (!vmask[k]) free_list.push_back(k);
        e.put_oh = '0;
        for (int s = 0; s < P; s++)
            if (s < free_list.size()) e.put_oh[s*E + free_list[s]] = 1'b1;
        e.full = free_list.size() < P;
        win = -1;
        foreach (mq[q]) if (win < 0 && rdy[mq[q]]) win = mq[q];
        e.pick = (st || win < 0) ? '0 : (one << win);
        e.vv   = vmask;
        e.iv   = m_iss_v;
        e.idx  = m_iss_idx;
        e.perf = m_perf;
        sb.push_back(e);
        if (!st) begin
            m_iss_v   = (win >= 0);
            m_iss_idx = (win >= 0) ? IW'(win) : '0;
        end
        if (win >= 0 && st && m_perf != 32'hFFFF_FFFF) m_perf = m_perf + 1;
        for (int k = 0; k < E; k++) begin
            if (fin[k]) begin
                for (int q = mq.size() - 1; q >= 0; q--) if (mq[q] == k) mq.delete(q);
            end
        end
        if (!e.full) begin
            for (int s = 0; s < P; s++) if (pv[s]) mq.push_back(free_list[s]);
        end
    endtask

    task automatic step(input logic [P-1:0] pv, input logic [E-1:0] rdy,
                        input logic [E-1:0] fin, input logic st);
        @(posedge clk);
        #1;
        bus.i_put_vld      = pv;
        bus.i_entry_ready  = rdy;
        bus.i_entry_finish = fin;
        bus.i_pipe_stall   = st;
        apply_cycle(pv, rdy, fin, st);
    endtask

    // Reset is asserted mid-cycle so the next negedge sees whether it acts asynchronously.
    task automatic reset_dut();
        @(posedge clk);
        #1;
        rst_n              = 1'b0;
        bus.i_put_vld      = '0;
        bus.i_entry_ready  = '0;
        bus.i_entry_finish = '0;
        bus.i_pipe_stall   = 1'b0;
        model_reset();
        apply_cycle('0, '0, '0, 1'b0);
        @(posedge clk);
        #1;
        apply_cycle('0, '0, '0, 1'b0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    exp_t mon_e;
    always @(negedge clk) begin
        if (sb.size() != 0) begin
            mon_e = sb.pop_front();
            chk("pick_oh",      64'(bus.o_pick_oh),      64'(mon_e.pick));
            chk("full",         64'(bus.o_full),         64'(mon_e.full));
            chk("put_entry_oh", 64'(bus.o_put_entry_oh), 64'(mon_e.put_oh));
            chk("valid_vec",    64'(bus.o_valid_vec),    64'(mon_e.vv));
            chk("iss_valid",    64'(bus.o_iss_valid),    64'(mon_e.iv));
            chk("iss_idx",      64'(bus.o_iss_idx),      64'(mon_e.idx));
`ifdef MSRH_SCHED_PICK_PERF_EN
            chk("perf_cnt",     64'(perf_cnt),           64'(mon_e.perf));
`endif
        end
    end

    initial begin
        logic [E-1:0] fin;
        rst_n              = 1'b0;
        bus.i_put_vld      = '0;
        bus.i_entry_ready  = '0;
        bus.i_entry_finish = '0;
        bus.i_pipe_stall   = 1'b0;
        model_reset();
        reset_dut();

        // Two puts, then both ready: the slot-0 entry is older.
        step(2'b11, 8'h00, 8'h00, 1'b0);
        step(2'b00, 8'h03, 8'h00, 1'b0);
        step(2'b00, 8'h00, 8'h00, 1'b0);
        // Fill to 7 entries (full), finish 2, reallocate 2 as youngest.
        step(2'b11, 8'h00, 8'h00, 1'b0);
        step(2'b11, 8'h00, 8'h00, 1'b0);
        step(2'b01, 8'h00, 8'h00, 1'b0);
        step(2'b00, 8'h00, 8'h04, 1'b0);
        step(2'b01, 8'h00, 8'h00, 1'b0);
        step(2'b00, 8'h24, 8'h00, 1'b0);
        // Stall holds the issue register and suppresses the pick.
        step(2'b00, 8'h08, 8'h00, 1'b1);
        step(2'b00, 8'h08, 8'h00, 1'b1);
        step(2'b00, 8'h08, 8'h00, 1'b0);
        // Freed entry 0 is not allocatable in the cycle it finishes.
        step(2'b00, 8'h00, 8'h02, 1'b0);
        step(2'b01, 8'h00, 8'h01, 1'b0);
        step(2'b00, 8'h00, 8'h00, 1'b0);
        // Puts while full are ignored.
        step(2'b11, 8'h00, 8'h00, 1'b0);
        step(2'b11, 8'hFF, 8'h00, 1'b0);

        for (int n = 0; n < 1500; n++) begin
            for (int k = 0; k < E; k++) fin[k] = ($urandom_range(0, 5) == 0);
            step(P'($urandom_range(0, 3)), E'($urandom), fin, $urandom_range(0, 3) == 0);
        end

        // Reset with 6 entries live and the issue register valid.
        reset_dut();
        step(2'b11, 8'h00, 8'h00, 1'b0);
        step(2'b11, 8'h00, 8'h00, 1'b0);
        step(2'b11, 8'h00, 8'h00, 1'b1);
        step(2'b00, 8'hFF, 8'h00, 1'b1);
        step(2'b00, 8'hFF, 8'h00, 1'b0);
        reset_dut();
        step(2'b11, 8'h30, 8'h00, 1'b0);

        repeat (3) @(negedge clk);
        n_vec++;
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard_drain: %0d records left, expected 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
